// File: rtl/demuxn_if.sv
// Handshake bundle for demuxn: one producer side (data + control tokens)
// and M consumer channels, with the sticky error flag.
interface demuxn_if #(
  parameter int N = 32,
  parameter int M = 4
);
  localparam int S = $clog2(M + 1);

  logic           r_i;
  logic           a_i;
  logic [N-1:0]   d_i;
  logic           rctl_i;
  logic [S-1:0]   dctl_i;
  logic           actl_i;
  logic [M-1:0]   r_o;
  logic [M-1:0]   a_o;
  logic [M*N-1:0] d_o;
  logic           err_o;

  // master is the environment: the producer plus all consumers
  modport master (
    output r_i, d_i, rctl_i, dctl_i, a_o,
    input  a_i, actl_i, r_o, d_o, err_o
  );

  modport slave (
    input  r_i, d_i, rctl_i, dctl_i, a_o,
    output a_i, actl_i, r_o, d_o, err_o
  );
endinterface

// File: rtl/demuxn.sv
// Clocked M-way four-phase demux: joins a data token with a control token and
// steers the data to one channel, all channels (broadcast) or drops it.
module demuxn #(
  parameter int   N     = 32,
  parameter int   M     = 4,
  parameter logic BCAST = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  demuxn_if.slave  bus
);
  localparam int S = $clog2(M + 1);

  typedef enum logic [1:0] {IDLE, ACK, SEND, RTZ} state_t;

  state_t       state_q;
  logic [N-1:0] data_q;
  logic [S-1:0] sel_q;
  logic         ack_q;
  logic [M-1:0] r_q;
  logic         err_q;

  logic [M-1:0] cap_mask;
  logic [M-1:0] mask;
  logic [M-1:0] hit;

  // MASK is a pure function of SEL, so it is decoded from the held select
  // rather than stored a second time.
  function automatic logic [M-1:0] decode(input logic [S-1:0] s);
    logic [M-1:0] m;
    m = '0;
    for (int k = 0; k < M; k++)
      if (s == S'(k)) m[k] = 1'b1;
    if (BCAST && s == S'(M)) m = '1;
    return m;
  endfunction

  assign cap_mask = decode(bus.dctl_i);
  assign mask     = decode(sel_q);
  assign hit      = bus.a_o & mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.r_i && bus.rctl_i) begin
          data_q  <= bus.d_i;
          sel_q   <= bus.dctl_i;
          ack_q   <= 1'b1;
          if (cap_mask == '0) err_q <= 1'b1;
          state_q <= ACK;
        end
        ACK: if (!bus.r_i && !bus.rctl_i) begin
          ack_q <= 1'b0;
          // a dropped token finishes its input handshake and goes quiet
          if (mask != '0) begin
            r_q     <= mask;
            state_q <= SEND;
          end else begin
            state_q <= IDLE;
          end
        end
        SEND: if (hit == mask) begin
          r_q     <= '0;
          state_q <= RTZ;
        end
        RTZ: if (hit == '0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a_i    = ack_q;
  assign bus.actl_i = ack_q;
  assign bus.r_o    = r_q;
  assign bus.err_o  = err_q;

  for (genvar k = 0; k < M; k++) begin : g_lane
    assign bus.d_o[k*N +: N] = data_q;
  end
endmodule

// File: doc/demuxn.md
# demuxn

Clocked M-way successor of the two-way four-phase demux. One data token (r_i/a_i/d_i) and one control token (rctl_i/actl_i/dctl_i) are consumed together. The data is steered to output channel dctl_i, broadcast to all channels, or dropped with a sticky error flag. The block sits between a bundled-data producer and M consumers in the synchronous islands of the handshake fabric, and holds a one-token register.

## Interface
- N, 32, data width in bits
- M, 4, number of output channels (M >= 2)
- BCAST, 1'b1, when 1, select value M means broadcast to all channels
- S (localparam), $clog2(M+1), select width
- clk  in  1  clock; all handshake inputs are synchronous to it
- rst  in  1  asynchronous, active-low reset
- r_i  in  1  data request
- a_i  out  1  data acknowledge
- d_i  in  N  data
- rctl_i  in  1  control request
- dctl_i  in  S  channel select
- actl_i  out  1  control acknowledge
- r_o  out  M  per-channel request; bit k belongs to channel k
- a_o  in  M  per-channel acknowledge
- d_o  out  M*N  lane k is d_o[k*N +: N]; every lane carries the data register
- err_o  out  1  sticky: set when a token was dropped

## Operation
- Protocol: four-phase return-to-zero on every channel. Handshake outputs come straight from registers, with no combinational input-to-output path.
- Registers: DATA (N bits), SEL (S bits), MASK (M bits), state, err.
- Reset (rst=0, asynchronous): state=IDLE, a_i=0, actl_i=0, r_o=0, err_o=0, DATA=0, SEL=0, MASK=0. Reset during any state abandons the token with no completion.
- IDLE
  - Waits for r_i=1 and rctl_i=1 sampled in the same cycle. Either request alone is ignored and left pending.
  - On capture: DATA<=d_i, SEL<=dctl_i, go to ACK.
  - MASK is computed as follows:
    - SEL<M: MASK = one-hot(SEL).
    - SEL==M and BCAST=1: MASK = all ones.
    - Otherwise: MASK=0 and err<=1.
- ACK: a_i=1 and actl_i=1. Wait until r_i=0 and rctl_i=0 are sampled together, then drop both acks.
  - MASK!=0: go to SEND.
  - MASK==0: go to IDLE.
- SEND: r_o=MASK. Wait until (a_o & MASK)==MASK, then go to RTZ with r_o<=0.
- RTZ: r_o=0. Wait until (a_o & MASK)==0, then go to IDLE.
- DATA stays stable from capture until the next capture. Lanes not in MASK also show DATA, but their r_o stays 0.
- a_o bits outside MASK are ignored in every state. New tokens are not accepted until the block is back in IDLE.
- err_o stays set until reset; further drops have no additional effect.

## Timing
- Each transition takes effect on the clk edge at which its condition is sampled. The registered output is visible from that edge.
- Capture at edge t gives a_i=actl_i=1 from t.
- Releases sampled low at edge u: acks drop at u and r_o rises at u. Minimum is one cycle after capture.
- All acks sampled high at edge v: r_o falls at v.
- All acks sampled low at edge w: block is in IDLE at w. The earliest next capture is at w+1.
- Minimum unicast cycle, with an immediately responding environment: 4 clk edges per token.
- Broadcast waits for the slowest consumer in both phases.
- Dropped tokens complete the input handshake normally; downstream sees no activity.

## Test plan
- Unicast, M=4, N=32: d_i=0xDEADBEEF, dctl_i=2 -> a_i and actl_i rise together; after release, r_o=4'b0100 and lane 2=0xDEADBEEF; a_o[2] high -> r_o=0; a_o[2] low -> IDLE; err_o=0.
- Broadcast: dctl_i=4, with a_o[0..2] high immediately and a_o[3] high 5 cycles later -> r_o=4'b1111 is held until a_o[3] rises. The return phase likewise waits for the last a_o to fall.
- Drop: dctl_i=5 and 7 (M=4) -> input acks complete, r_o stays 0, and err_o=1 persists through a following valid unicast to channel 0.
- Skew and isolation:
  - rctl_i high 3 cycles before r_i -> capture only once both are high.
  - r_i released 2 cycles before rctl_i -> acks held until both are low.
  - Toggling a_o[1] during a channel-0 transfer has no effect.
- Reset mid-operation: assert rst=0 in SEND -> r_o, a_i, actl_i and err_o go to 0 immediately without a clock. After rst=1 the block accepts a fresh token.
- Back-to-back: 8 unicast tokens cycling channels 0..3 with an immediate-ack environment -> each token takes exactly 4 edges, and data on each lane matches the order of issue.
